// File: rtl/qrisc32_mem_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch and data access.
// Data wins by default; a saturating starvation counter forces an instruction grant.
module qrisc32_mem_arbiter #(
  parameter int STARVE_LIMIT = 4  // legal range 1..7
) (
  input  logic        clk,
  input  logic        areset,
  // instruction fetch port
  input  logic [31:0] i_address,
  input  logic        i_rd,
  output logic [31:0] i_data_r,
  output logic        i_wait_req,
  // data port
  input  logic [31:0] d_address,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_data_w,
  output logic [31:0] d_data_r,
  output logic        d_wait_req,
  // shared memory master
  output logic [31:0] m_address,
  output logic [31:0] m_data_w,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [31:0] m_data_r,
  input  logic        m_wait_req,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_I = 2'b01,
    OWN_D = 2'b10
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [2:0] starve_cnt;
  logic       d_req;
  logic       done;

  assign d_req = d_rd | d_wr;
  assign done  = ~m_wait_req;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment up front keeps this combinational block latch-free.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req && (starve_cnt < LIMIT)) state_nxt = OWN_D;
        else if (i_rd)                     state_nxt = OWN_I;
        else if (d_req)                    state_nxt = OWN_D;
      end
      OWN_I, OWN_D: begin
        // Dropped requests do not abort; only memory completion releases ownership.
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counts back-to-back data grants that completed while a fetch was pending.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      starve_cnt <= 3'd0;
    end else if (done) begin
      if (state == OWN_D) begin
        if (!i_rd)                    starve_cnt <= 3'd0;
        else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 3'd1;
      end else if (state == OWN_I) begin
        starve_cnt <= 3'd0;
      end
    end
  end

  // Outputs decode from state only, so reset forcing IDLE forces them immediately.
  always_comb begin
    owner      = state;
    m_address  = 32'd0;
    m_data_w   = 32'd0;
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    i_wait_req = 1'b1;
    d_wait_req = 1'b1;
    i_data_r   = 32'd0;
    d_data_r   = 32'd0;
    case (state)
      OWN_I: begin
        m_address  = i_address;
        m_rd       = i_rd;
        i_wait_req = m_wait_req;
        i_data_r   = m_data_r;
      end
      OWN_D: begin
        m_address  = d_address;
        m_wr       = d_wr;
        m_data_w   = d_data_w;
        m_rd       = d_rd & ~d_wr;  // simultaneous rd+wr executes as a write
        d_wait_req = m_wait_req;
        d_data_r   = m_data_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qrisc32_mem_arbiter.sv
// Directed self-checking bench for qrisc32_mem_arbiter (STARVE_LIMIT = 4).
// Inputs change 2 ns after each rising edge; outputs are checked 1 ns later.
module tb_qrisc32_mem_arbiter;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] i_address, d_address, d_data_w, m_data_r;
  logic        i_rd, d_rd, d_wr, m_wait_req;
  logic [31:0] i_data_r, d_data_r, m_address, m_data_w;
  logic        i_wait_req, d_wait_req, m_rd, m_wr;
  logic [1:0]  owner;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  qrisc32_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .areset     (areset),
    .i_address  (i_address),
    .i_rd       (i_rd),
    .i_data_r   (i_data_r),
    .i_wait_req (i_wait_req),
    .d_address  (d_address),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .d_data_w   (d_data_w),
    .d_data_r   (d_data_r),
    .d_wait_req (d_wait_req),
    .m_address  (m_address),
    .m_data_w   (m_data_w),
    .m_rd       (m_rd),
    .m_wr       (m_wr),
    .m_data_r   (m_data_r),
    .m_wait_req (m_wait_req),
    .owner      (owner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Reset values of every output.
  task automatic check_idle_outputs(input string tag);
    check({tag, ".owner"},  32'(owner),      32'd0);
    check({tag, ".m_rd"},   32'(m_rd),       32'd0);
    check({tag, ".m_wr"},   32'(m_wr),       32'd0);
    check({tag, ".m_addr"}, m_address,       32'd0);
    check({tag, ".m_dw"},   m_data_w,        32'd0);
    check({tag, ".i_wait"}, 32'(i_wait_req), 32'd1);
    check({tag, ".d_wait"}, 32'(d_wait_req), 32'd1);
    check({tag, ".i_dr"},   i_data_r,        32'd0);
    check({tag, ".d_dr"},   d_data_r,        32'd0);
  endtask

  // Expected grant order and starve count after each completion with both requesters busy.
  logic [1:0] exp_grant  [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
                                  2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
  logic [2:0] exp_starve [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0,
                                  3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    i_address = 32'd0; i_rd = 1'b0;
    d_address = 32'd0; d_rd = 1'b0; d_wr = 1'b0; d_data_w = 32'd0;
    m_data_r = 32'h5555_0000; m_wait_req = 1'b0;

    // Reset state
    tick(); tick();
    settle();
    check_idle_outputs("reset");
    check("reset.starve", 32'(dut.starve_cnt), 32'd0);

    // Single instruction fetch
    tick();
    areset = 1'b0;
    i_rd = 1'b1; i_address = 32'h10; m_data_r = 32'hA5A5_A5A5;
    settle();
    check("ifetch.c1.owner",  32'(owner),      32'd0);
    check("ifetch.c1.i_wait", 32'(i_wait_req), 32'd1);
    tick(); settle();
    check("ifetch.c2.owner",  32'(owner),      32'd1);
    check("ifetch.c2.m_addr", m_address,       32'h10);
    check("ifetch.c2.m_rd",   32'(m_rd),       32'd1);
    check("ifetch.c2.m_wr",   32'(m_wr),       32'd0);
    check("ifetch.c2.i_wait", 32'(i_wait_req), 32'd0);
    check("ifetch.c2.i_dr",   i_data_r,        32'hA5A5_A5A5);
    check("ifetch.c2.d_wait", 32'(d_wait_req), 32'd1);
    check("ifetch.c2.d_dr",   d_data_r,        32'd0);
    i_rd = 1'b0;
    tick(); settle();
    check_idle_outputs("ifetch.c3");

    // Write beats pending fetch (starve 0 -> 1)
    i_rd = 1'b1; i_address = 32'h20;
    d_wr = 1'b1; d_address = 32'h100; d_data_w = 32'h1234;
    tick(); settle();
    check("dwr.owner",  32'(owner),      32'd2);
    check("dwr.m_wr",   32'(m_wr),       32'd1);
    check("dwr.m_rd",   32'(m_rd),       32'd0);
    check("dwr.m_addr", m_address,       32'h100);
    check("dwr.m_dw",   m_data_w,        32'h1234);
    check("dwr.i_wait", 32'(i_wait_req), 32'd1);
    check("dwr.d_wait", 32'(d_wait_req), 32'd0);
    check("dwr.i_dr",   i_data_r,        32'd0);
    tick();
    i_rd = 1'b0; d_wr = 1'b0;
    settle();
    check("dwr.idle.owner", 32'(owner),           32'd0);
    check("dwr.starve",     32'(dut.starve_cnt),  32'd1);

    // Simultaneous rd+wr is a write; completion without fetch clears starve
    d_rd = 1'b1; d_wr = 1'b1; d_data_w = 32'hCAFE;
    tick(); settle();
    check("rdwr.owner", 32'(owner), 32'd2);
    check("rdwr.m_wr",  32'(m_wr),  32'd1);
    check("rdwr.m_rd",  32'(m_rd),  32'd0);
    d_rd = 1'b0; d_wr = 1'b0;
    tick(); settle();
    check("rdwr.idle.owner", 32'(owner),          32'd0);
    check("rdwr.starve",     32'(dut.starve_cnt), 32'd0);

    // Data read stalled 3 cycles, request dropped mid-transfer
    d_rd = 1'b1; d_address = 32'h200; m_wait_req = 1'b1; m_data_r = 32'hDEAD_BEEF;
    tick();
    d_rd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("stall.c%0d.owner", k + 1), 32'(owner),      32'd2);
      check($sformatf("stall.c%0d.d_wait", k + 1), 32'(d_wait_req), 32'd1);
      tick();
    end
    m_wait_req = 1'b0;
    settle();
    check("stall.c4.owner",  32'(owner),      32'd2);
    check("stall.c4.d_wait", 32'(d_wait_req), 32'd0);
    check("stall.c4.d_dr",   d_data_r,        32'hDEAD_BEEF);
    tick(); settle();
    check("stall.idle.owner", 32'(owner), 32'd0);

    // Starvation: both requesting continuously
    i_rd = 1'b1; d_rd = 1'b1; m_wait_req = 1'b0;
    for (int g = 0; g < 10; g++) begin
      settle();
      check($sformatf("starve.g%0d.idle", g), 32'(owner), 32'd0);
      tick(); settle();
      check($sformatf("starve.g%0d.owner", g), 32'(owner), 32'(exp_grant[g]));
      tick();
      check($sformatf("starve.g%0d.cnt", g), 32'(dut.starve_cnt), 32'(exp_starve[g]));
    end

    // Reset mid-OWN_I: no completion may leak out
    d_rd = 1'b0; i_rd = 1'b1; i_address = 32'h40; m_wait_req = 1'b1; m_data_r = 32'h7777_7777;
    settle();
    tick(); settle();
    check("rst.pre.owner",  32'(owner),      32'd1);
    check("rst.pre.i_wait", 32'(i_wait_req), 32'd1);
    #1;
    areset = 1'b1; m_wait_req = 1'b0;
    #0.5;
    check_idle_outputs("rst.async");
    tick(); settle();
    check_idle_outputs("rst.held");
    areset = 1'b0;
    settle();
    check("rst.rel.owner", 32'(owner), 32'd0);
    tick(); settle();
    check("rst.rel.grant", 32'(owner),      32'd1);
    check("rst.rel.i_wait", 32'(i_wait_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
